// File: rtl/sd_blk_bram_packer.sv
// Packs an SD block byte stream into 64-bit words written to BRAM port A; 9 cycles/word minimum, done 1 cycle after last write.
// byte_rdy is high only in PACK and never depends on byte_vld; the write cycle stalls the stream for one cycle.
module sd_blk_bram_packer #(
  parameter int WORDS_PER_BLK = 64,
  parameter bit BIG_ENDIAN    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [5:0]  i_base_addr,
  input  logic        i_abort,
  input  logic [7:0]  i_byte_in,
  input  logic        i_byte_vld,
  output logic        o_byte_rdy,
  output logic [6:0]  o_bram_addr,
  output logic [63:0] o_bram_data,
  output logic        o_bram_wr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [6:0]  o_word_cnt
);

  localparam logic [6:0] LP_LAST = 7'(WORDS_PER_BLK);

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_WRITE, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_base;
  logic [3:0]  r_byte_cnt;
  logic [6:0]  r_word_cnt;
  logic [63:0] r_shift;
  logic [5:0]  r_addr;
  logic [63:0] r_data;
  logic        r_wr;
  logic        r_done;
  logic        r_err;

  logic        w_xfer;
  logic        w_last_byte;
  logic        w_last_word;
  logic        w_start_ok;
  logic [63:0] w_shift_nxt;

  assign w_xfer      = i_byte_vld && (r_state == S_PACK);
  assign w_last_byte = w_xfer && (r_byte_cnt == 4'd7);
  assign w_last_word = (r_word_cnt + 7'd1) == LP_LAST;
  assign w_start_ok  = i_start && !i_abort;
  // First byte of a word ends up in the top byte (big endian) or the bottom byte (little endian).
  assign w_shift_nxt = BIG_ENDIAN ? {r_shift[55:0], i_byte_in} : {i_byte_in, r_shift[63:8]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_PACK;
      S_PACK:  begin
        if (i_abort)          w_state_nxt = S_IDLE;
        else if (w_last_byte) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (i_abort)          w_state_nxt = S_IDLE;
        else if (w_last_word) w_state_nxt = S_DONE;
        else                  w_state_nxt = S_PACK;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_base     <= '0;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_wr       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= (r_state != S_IDLE) && (i_start || i_abort);
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_base     <= i_base_addr;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
          end
        end
        S_PACK: begin
          if (i_abort) begin
            r_byte_cnt <= '0;
          end else if (w_xfer) begin
            r_shift    <= w_shift_nxt;
            r_byte_cnt <= r_byte_cnt + 4'd1;
            if (w_last_byte) begin
              r_wr   <= 1'b1;
              r_data <= w_shift_nxt;
              r_addr <= r_base + r_word_cnt[5:0];
            end
          end
        end
        S_WRITE: begin
          // The write is already on the port this cycle, so it counts even if aborted.
          r_byte_cnt <= '0;
          r_word_cnt <= r_word_cnt + 7'd1;
          if (!i_abort && w_last_word) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_byte_rdy  = (r_state == S_PACK);
  assign o_busy      = (r_state != S_IDLE);
  assign o_bram_addr = {1'b0, r_addr};
  assign o_bram_data = r_data;
  assign o_bram_wr   = r_wr;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_sd_blk_bram_packer.sv
// Drives a big-endian and a little-endian packer with the same byte stream and checks
// the BRAM images they build against words assembled directly from the stream.
module tb_sd_blk_bram_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort, byte_vld;
  logic [5:0] base_addr;
  logic [7:0] byte_in;

  logic        rdy_b, wr_b, busy_b, done_b, err_b;
  logic [6:0]  addr_b, wcnt_b;
  logic [63:0] data_b;
  logic        rdy_l, wr_l, busy_l, done_l, err_l;
  logic [6:0]  addr_l, wcnt_l;
  logic [63:0] data_l;

  sd_blk_bram_packer #(.WORDS_PER_BLK(64), .BIG_ENDIAN(1'b1)) u_be (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base_addr), .i_abort(abort),
    .i_byte_in(byte_in), .i_byte_vld(byte_vld), .o_byte_rdy(rdy_b), .o_bram_addr(addr_b),
    .o_bram_data(data_b), .o_bram_wr(wr_b), .o_busy(busy_b), .o_done(done_b), .o_err(err_b),
    .o_word_cnt(wcnt_b)
  );

  sd_blk_bram_packer #(.WORDS_PER_BLK(64), .BIG_ENDIAN(1'b0)) u_le (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base_addr), .i_abort(abort),
    .i_byte_in(byte_in), .i_byte_vld(byte_vld), .o_byte_rdy(rdy_l), .o_bram_addr(addr_l),
    .o_bram_data(data_l), .o_bram_wr(wr_l), .o_busy(busy_l), .o_done(done_l), .o_err(err_l),
    .o_word_cnt(wcnt_l)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM images and event counters, built from what the packers put on port A.
  logic [63:0] ram_b [64];
  logic [63:0] ram_l [64];
  logic [5:0]  waddr_q [$];
  int wr_cnt_b = 0, wr_cnt_l = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0, addr6_bad = 0;

  always @(negedge clk) begin
    if (wr_b) begin
      ram_b[addr_b[5:0]] = data_b;
      waddr_q.push_back(addr_b[5:0]);
      wr_cnt_b++;
      if (addr_b[6]) addr6_bad++;
    end
    if (wr_l) begin
      ram_l[addr_l[5:0]] = data_l;
      wr_cnt_l++;
      if (addr_l[6]) addr6_bad++;
    end
    if (done_b) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_b) err_cnt++;
  end

  logic [7:0] blk [512];
  int sent = 0;
  int start_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int k, input bit be);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 8; j++) begin
      if (be) w[63-8*j -: 8] = blk[8*k+j];
      else    w[8*j +: 8]    = blk[8*k+j];
    end
    return w;
  endfunction

  function automatic int ram_mismatch(input int base, input int nwords);
    int m;
    int a;
    m = 0;
    for (int k = 0; k < nwords; k++) begin
      a = (base + k) % 64;
      if (ram_b[a] !== exp_word(k, 1'b1)) m++;
      if (ram_l[a] !== exp_word(k, 1'b0)) m++;
    end
    return m;
  endfunction

  function automatic int addr_order_bad(input int q0, input int base, input int n);
    int m;
    m = 0;
    for (int k = 0; k < n; k++)
      if (q0 + k >= waddr_q.size() || waddr_q[q0+k] !== 6'((base + k) % 64)) m++;
    return m;
  endfunction

  task automatic fill(input bit ramp);
    for (int i = 0; i < 512; i++) blk[i] = ramp ? 8'(i) : 8'($urandom_range(255));
  endtask

  task automatic start_blk(input logic [5:0] base);
    @(negedge clk);
    byte_vld  = 1'b0;
    start     = 1'b1;
    base_addr = base;
    sent      = 0;
    start_cyc = cyc + 1;
  endtask

  task automatic feed(input string tag, input int nbytes, input int gap_pct);
    int n;
    int guard;
    n = 0;
    guard = 0;
    while (n < nbytes && guard < 20000) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        byte_vld = 1'b0;
      end else begin
        byte_vld = 1'b1;
        byte_in  = blk[sent];
      end
      if (byte_vld && rdy_b) begin
        n++;
        sent++;
      end
    end
    chk({tag, "_feed_budget"}, 64'(n), 64'(nbytes));
  endtask

  task automatic wait_done(input string tag);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      byte_vld = 1'b0;
      start    = 1'b0;
      g++;
    end while (!done_b && g < 3000);
    chk({tag, "_done_seen"}, 64'(done_b), 64'(1));
    #2;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_data_be"}, data_b, 64'h0);
    chk({tag, "_ctl_be"}, 64'({rdy_b, addr_b, wr_b, busy_b, done_b, err_b, wcnt_b}), 64'h0);
    chk({tag, "_data_le"}, data_l, 64'h0);
    chk({tag, "_ctl_le"}, 64'({rdy_l, addr_l, wr_l, busy_l, done_l, err_l, wcnt_l}), 64'h0);
  endtask

  task automatic full_block(input string tag, input logic [5:0] base, input int gap_pct);
    int w0, wl0, d0, e0, q0;
    w0 = wr_cnt_b; wl0 = wr_cnt_l; d0 = done_cnt; e0 = err_cnt; q0 = waddr_q.size();
    start_blk(base);
    feed(tag, 512, gap_pct);
    wait_done(tag);
    chk({tag, "_writes_be"}, 64'(wr_cnt_b - w0), 64'd64);
    chk({tag, "_writes_le"}, 64'(wr_cnt_l - wl0), 64'd64);
    chk({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_err_cnt"}, 64'(err_cnt - e0), 64'd0);
    chk({tag, "_addr_order"}, 64'(addr_order_bad(q0, int'(base), 64)), 64'd0);
    chk({tag, "_ram"}, 64'(ram_mismatch(int'(base), 64)), 64'd0);
    repeat (3) @(negedge clk);
    #2;
    chk({tag, "_busy_after"}, 64'({busy_b, busy_l}), 64'd0);
    chk({tag, "_wcnt_hold"}, 64'({wcnt_b, wcnt_l}), 64'({7'd64, 7'd64}));
  endtask

  initial begin
    int w0, d0, e0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; byte_vld = 1'b0;
    base_addr = '0; byte_in = '0;
    repeat (3) @(negedge clk);
    #2;
    check_idle_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Ramp stream, valid held high: exact timing and the first packed words.
    fill(1'b1);
    full_block("ramp", 6'd0, 0);
    chk("ramp_latency", 64'(done_cyc - start_cyc + 1), 64'd577);
    chk("ramp_word0_be", ram_b[0], 64'h0001020304050607);
    chk("ramp_word0_le", ram_l[0], 64'h0706050403020100);
    chk("ramp_word1_be", ram_b[1], 64'h08090A0B0C0D0E0F);

    // Same stream with random valid gaps must build the same image.
    full_block("ramp_gaps", 6'd0, 40);
    chk("gaps_word0_le", ram_l[0], 64'h0706050403020100);

    // Address wrap from base 60.
    fill(1'b0);
    full_block("wrap", 6'd60, 20);
    chk("wrap_addr6", 64'(addr6_bad), 64'd0);

    // Start and abort together in IDLE, and abort alone in IDLE: nothing happens.
    e0 = err_cnt;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b0;
    @(negedge clk); #2;
    chk("idle_start_abort_busy", 64'(busy_b), 64'd0);
    chk("idle_start_abort_err", 64'(err_cnt - e0), 64'd0);

    // Abort after 100 bytes: 12 words land, no done, one err, back to IDLE.
    fill(1'b0);
    w0 = wr_cnt_b; d0 = done_cnt; e0 = err_cnt;
    start_blk(6'd5);
    feed("abort", 100, 30);
    @(negedge clk); byte_vld = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("abort_writes", 64'(wr_cnt_b - w0), 64'd12);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_err", 64'(err_cnt - e0), 64'd1);
    chk("abort_idle", 64'({busy_b, rdy_b}), 64'd0);
    chk("abort_wcnt", 64'(wcnt_b), 64'd12);
    chk("abort_ram", 64'(ram_mismatch(5, 12)), 64'd0);
    fill(1'b0);
    full_block("after_abort", 6'd9, 25);

    // Start while busy at word 10: err pulse, block carries on from the original base.
    fill(1'b0);
    w0 = wr_cnt_b; d0 = done_cnt; e0 = err_cnt;
    start_blk(6'd20);
    feed("restart", 84, 10);
    @(negedge clk); byte_vld = 1'b0; start = 1'b1; base_addr = 6'd50;
    feed("restart2", 428, 10);
    wait_done("restart");
    chk("restart_err", 64'(err_cnt - e0), 64'd1);
    chk("restart_writes", 64'(wr_cnt_b - w0), 64'd64);
    chk("restart_done", 64'(done_cnt - d0), 64'd1);
    chk("restart_ram", 64'(ram_mismatch(20, 64)), 64'd0);

    // Reset in the middle of word 20: outputs drop at once, nothing more is written.
    fill(1'b0);
    w0 = wr_cnt_b; d0 = done_cnt;
    start_blk(6'd0);
    feed("midreset", 20 * 8 + 3, 0);
    @(negedge clk); byte_vld = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_idle_zero("midreset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    chk("midreset_writes", 64'(wr_cnt_b - w0), 64'd20);
    chk("midreset_no_done", 64'(done_cnt - d0), 64'd0);
    chk("midreset_ram", 64'(ram_mismatch(0, 20)), 64'd0);
    chk("midreset_idle", 64'({busy_b, wcnt_b}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
